// File: rtl/m68k_bus_checkpoint_pkg.sv
// Purpose: shared debug-event definitions: field widths, timeout index, event word, default timeout.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package m68k_bus_checkpoint_pkg;

    localparam int EVT_IDX_W  = 5;
    localparam int EVT_ADDR_W = 24;
    localparam int EVT_CYC_W  = 32;

    // Event index reserved for bus-timeout events; never a table entry index.
    localparam logic [EVT_IDX_W-1:0] EVT_IDX_TIMEOUT = 5'h1F;

    // Default nAS-low budget in CLK_24M cycles before a bus timeout is flagged.
    localparam int DEF_TIMEOUT = 255;

    // Event word, MSB first: {RW, CYC, ADDR, IDX}.
    typedef struct packed {
        logic                  rw;
        logic [EVT_CYC_W-1:0]  cyc;
        logic [EVT_ADDR_W-1:0] addr;
        logic [EVT_IDX_W-1:0]  idx;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    // Rebuild the byte address: only a lower-byte-only access points at the odd byte.
    function automatic logic [EVT_ADDR_W-1:0] byte_addr(input logic [22:0] addr,
                                                        input logic       lds_n,
                                                        input logic       uds_n);
        return {addr, (~lds_n & uds_n)};
    endfunction

endpackage

// File: rtl/m68k_bus_checkpoint_fifo.sv
// Purpose: generic synchronous FIFO with simultaneous push/pop.
// Latency: 1 cycle from push to pop_vld (no bypass).
// Backpressure: push_rdy low when full unless a pop happens in the same cycle.
module m68k_bus_checkpoint_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             core_clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             empty, full, do_push, do_pop;

    // Pointer-compare status; a same-cycle pop makes room for the push.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_vld  = ~empty;
        do_pop   = ~empty & pop_rdy;
        push_rdy = ~full | do_pop;
        do_push  = push_vld & push_rdy;
        pop_dat  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next pointers and storage contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: slots are only read after being written.
    always_ff @(posedge core_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/m68k_bus_checkpoint.sv
// Purpose: 68K bus checkpoint monitor; matches bus byte addresses to a table, queues hit events, raises HALT.
// Latency: nAS fall -> 2 sync clks -> T0; EVT_VALID at T0+3 into an empty FIFO; HALT visible with the push.
// Backpressure: EVT_VALID/EVT_READY pop; full FIFO drops the event (OVERFLOW, DROP_CNT). NG_BUS_TIMEOUT_EN adds BUS_ERR.
module m68k_bus_checkpoint
    import m68k_bus_checkpoint_pkg::*;
#(
    parameter int NUM_CP     = 16,
    parameter int FIFO_DEPTH = 8
`ifdef NG_BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = DEF_TIMEOUT
`endif
) (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic [23:1] M68K_ADDR,
    input  logic        nAS,
    input  logic        nLDS,
    input  logic        nUDS,
    input  logic        M68K_RW,
    input  logic        CP_WE,
    input  logic [4:0]  CP_IDX,
    input  logic [23:0] CP_ADDR,
    input  logic        CP_EN,
    input  logic        CP_STOP,
    output logic        EVT_VALID,
    input  logic        EVT_READY,
    output logic [4:0]  EVT_IDX,
    output logic [23:0] EVT_ADDR,
    output logic [31:0] EVT_CYC,
    output logic        EVT_RW,
    output logic        HALT,
    input  logic        HALT_CLR,
    output logic        OVERFLOW,
    output logic [7:0]  DROP_CNT,
    output logic        BUS_ERR
);

    // Strobe vector order: {nAS, nUDS, nLDS}.
    // nAS syncs reset to 0 so a bus cycle already in flight at reset release never yields a T0.
    localparam logic [2:0] STRB_RST = 3'b011;

    logic [2:0]  strb_s1_q, strb_s1_d;
    logic [2:0]  strb_s2_q, strb_s2_d;
    logic        as_prev_q, as_prev_d;
    logic        t0;

    logic        cap_vld_q, cap_vld_d;
    logic [23:0] cap_addr_q, cap_addr_d;
    logic        cap_rw_q, cap_rw_d;
    logic [31:0] bus_cyc_q, bus_cyc_d;

    logic [23:0]       cp_addr_q [NUM_CP];
    logic [23:0]       cp_addr_d [NUM_CP];
    logic [NUM_CP-1:0] cp_en_q, cp_en_d;
    logic [NUM_CP-1:0] cp_stop_q, cp_stop_d;

    logic        hit, hit_stop;
    logic [4:0]  hit_idx;
    logic        m_vld_q, m_vld_d;
    logic        m_stop_q, m_stop_d;
    evt_t        m_evt_q, m_evt_d;

    logic        halt_q, halt_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        push_rdy, evt_vld, drop;
    evt_t        head_evt;

    // 2-FF synchronizer for the asynchronous strobes, plus last synced nAS for edge detect.
    always_comb begin
        strb_s1_d = {nAS, nUDS, nLDS};
        strb_s2_d = strb_s1_q;
        as_prev_d = strb_s2_q[2];
        t0        = as_prev_q & ~strb_s2_q[2];
    end

    // Synchronizer registers.
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            strb_s1_q <= STRB_RST;
            strb_s2_q <= STRB_RST;
            as_prev_q <= 1'b0;
        end else begin
            strb_s1_q <= strb_s1_d;
            strb_s2_q <= strb_s2_d;
            as_prev_q <= as_prev_d;
        end
    end

    // T0 capture: address/RW are stable while nAS is low, so they are sampled raw.
    always_comb begin
        cap_vld_d  = t0;
        cap_addr_d = cap_addr_q;
        cap_rw_d   = cap_rw_q;
        bus_cyc_d  = bus_cyc_q + 32'(t0);
        if (t0) begin
            cap_addr_d = byte_addr(M68K_ADDR, strb_s2_q[0], strb_s2_q[1]);
            cap_rw_d   = M68K_RW;
        end
    end

    // Capture-stage registers and the free-running bus-cycle counter.
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            cap_vld_q  <= 1'b0;
            cap_addr_q <= '0;
            cap_rw_q   <= 1'b0;
            bus_cyc_q  <= '0;
        end else begin
            cap_vld_q  <= cap_vld_d;
            cap_addr_q <= cap_addr_d;
            cap_rw_q   <= cap_rw_d;
            bus_cyc_q  <= bus_cyc_d;
        end
    end

    // Table writes; out-of-range indices match no entry and are ignored.
    always_comb begin
        cp_addr_d = cp_addr_q;
        cp_en_d   = cp_en_q;
        cp_stop_d = cp_stop_q;
        for (int i = 0; i < NUM_CP; i++) begin
            if (CP_WE && (CP_IDX == 5'(i))) begin
                cp_addr_d[i] = CP_ADDR;
                cp_en_d[i]   = CP_EN;
                cp_stop_d[i] = CP_STOP;
            end
        end
    end

    // Checkpoint table registers; a same-cycle write is seen by the next compare only.
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            for (int i = 0; i < NUM_CP; i++) begin
                cp_addr_q[i] <= '0;
            end
            cp_en_q   <= '0;
            cp_stop_q <= '0;
        end else begin
            cp_addr_q <= cp_addr_d;
            cp_en_q   <= cp_en_d;
            cp_stop_q <= cp_stop_d;
        end
    end

`ifdef NG_BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    logic [7:0] to_cnt_q, to_cnt_d;
    logic       to_fire;
    logic       bus_err_q, bus_err_d;

    // nAS-low watchdog: counts up to TO_LIMIT, holds there, fires once on arrival.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        to_fire   = 1'b0;
        if (strb_s2_q[2]) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LIMIT) begin
            to_cnt_d = to_cnt_q + 8'd1;
            to_fire  = (to_cnt_d == TO_LIMIT);
        end
        bus_err_d = bus_err_q | to_fire;
    end

    // Watchdog registers; BUS_ERR is only cleared by reset.
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign BUS_ERR = bus_err_q;
`else
    assign BUS_ERR = 1'b0;
`endif

    // Parallel compare; scanning high to low lets the lowest matching index win.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_stop = 1'b0;
        for (int i = NUM_CP - 1; i >= 0; i--) begin
            if (cp_en_q[i] && (cp_addr_q[i] == cap_addr_q)) begin
                hit      = 1'b1;
                hit_idx  = 5'(i);
                hit_stop = cp_stop_q[i];
            end
        end
        m_vld_d      = cap_vld_q & hit;
        m_stop_d     = cap_vld_q & hit & hit_stop;
        m_evt_d.rw   = cap_rw_q;
        m_evt_d.cyc  = bus_cyc_q;
        m_evt_d.addr = cap_addr_q;
        m_evt_d.idx  = hit_idx;
`ifdef NG_BUS_TIMEOUT_EN
        // Timeout reuses the match slot; a capture in the same cycle (tiny TIMEOUT only) takes priority.
        if (to_fire && !cap_vld_q) begin
            m_vld_d     = 1'b1;
            m_stop_d    = 1'b0;
            m_evt_d.idx = EVT_IDX_TIMEOUT;
        end
`endif
    end

    // Match-stage registers; this is the push request into the event FIFO.
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            m_vld_q  <= 1'b0;
            m_stop_q <= 1'b0;
            m_evt_q  <= '0;
        end else begin
            m_vld_q  <= m_vld_d;
            m_stop_q <= m_stop_d;
            m_evt_q  <= m_evt_d;
        end
    end

    m68k_bus_checkpoint_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_evt_fifo (
        .core_clk (CLK_24M),
        .rst_n    (nRESET),
        .push_vld (m_vld_q),
        .push_dat (m_evt_q),
        .push_rdy (push_rdy),
        .pop_vld  (evt_vld),
        .pop_rdy  (EVT_READY),
        .pop_dat  (head_evt)
    );

    // Sticky status: a set in the same cycle as HALT_CLR wins.
    always_comb begin
        drop       = m_vld_q & ~push_rdy;
        halt_d     = (m_vld_q & m_stop_q) | (halt_q & ~HALT_CLR);
        ovf_d      = drop | (ovf_q & ~HALT_CLR);
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Status registers.
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            halt_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            halt_q     <= halt_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Head fields are forced to zero when empty so stale storage never shows.
    assign EVT_VALID = evt_vld;
    assign EVT_IDX   = evt_vld ? head_evt.idx  : '0;
    assign EVT_ADDR  = evt_vld ? head_evt.addr : '0;
    assign EVT_CYC   = evt_vld ? head_evt.cyc  : '0;
    assign EVT_RW    = evt_vld ? head_evt.rw   : 1'b0;
    assign HALT      = halt_q;
    assign OVERFLOW  = ovf_q;
    assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_m68k_bus_checkpoint.sv
// Purpose: directed self-checking bench for m68k_bus_checkpoint.
// Latency: drives on negedge, samples on negedge, fixed cycle counts only.
// Backpressure: exercises full-FIFO drop, pop-while-full and empty pops.
module tb_m68k_bus_checkpoint;

    logic        CLK_24M = 1'b0;
    logic        nRESET;
    logic [23:1] M68K_ADDR;
    logic        nAS, nLDS, nUDS, M68K_RW;
    logic        CP_WE;
    logic [4:0]  CP_IDX;
    logic [23:0] CP_ADDR;
    logic        CP_EN, CP_STOP;
    logic        EVT_VALID, EVT_READY;
    logic [4:0]  EVT_IDX;
    logic [23:0] EVT_ADDR;
    logic [31:0] EVT_CYC;
    logic        EVT_RW, HALT, HALT_CLR, OVERFLOW, BUS_ERR;
    logic [7:0]  DROP_CNT;

    int checks = 0;
    int errors = 0;
    int exp_cyc = 0;

    always #5 CLK_24M = ~CLK_24M;

    m68k_bus_checkpoint #(
        .NUM_CP     (16),
        .FIFO_DEPTH (8)
`ifdef NG_BUS_TIMEOUT_EN
        ,
        .TIMEOUT    (20)
`endif
    ) dut (
        .CLK_24M   (CLK_24M),
        .nRESET    (nRESET),
        .M68K_ADDR (M68K_ADDR),
        .nAS       (nAS),
        .nLDS      (nLDS),
        .nUDS      (nUDS),
        .M68K_RW   (M68K_RW),
        .CP_WE     (CP_WE),
        .CP_IDX    (CP_IDX),
        .CP_ADDR   (CP_ADDR),
        .CP_EN     (CP_EN),
        .CP_STOP   (CP_STOP),
        .EVT_VALID (EVT_VALID),
        .EVT_READY (EVT_READY),
        .EVT_IDX   (EVT_IDX),
        .EVT_ADDR  (EVT_ADDR),
        .EVT_CYC   (EVT_CYC),
        .EVT_RW    (EVT_RW),
        .HALT      (HALT),
        .HALT_CLR  (HALT_CLR),
        .OVERFLOW  (OVERFLOW),
        .DROP_CNT  (DROP_CNT),
        .BUS_ERR   (BUS_ERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_24M);
    endtask

    task automatic cp_write(input logic [4:0] idx, input logic [23:0] a, input logic en, input logic stop);
        CP_WE = 1'b1; CP_IDX = idx; CP_ADDR = a; CP_EN = en; CP_STOP = stop;
        tick(1);
        CP_WE = 1'b0;
    endtask

    // Sets up address/strobes, then drops nAS at the next negedge.
    task automatic bus_start(input logic [23:1] a, input logic rw, input logic lds_n, input logic uds_n);
        M68K_ADDR = a; M68K_RW = rw; nLDS = lds_n; nUDS = uds_n;
        tick(1);
        nAS = 1'b0;
        exp_cyc++;
    endtask

    task automatic bus_end();
        nAS = 1'b1; nLDS = 1'b1; nUDS = 1'b1;
        tick(4);
    endtask

    task automatic bus_cycle(input logic [23:1] a, input logic rw, input logic lds_n, input logic uds_n);
        bus_start(a, rw, lds_n, uds_n);
        tick(9);
        bus_end();
    endtask

    task automatic expect_evt(input string tag, input logic [4:0] idx, input logic [23:0] a,
                              input int cyc, input logic rw);
        chk({tag, ".vld"},  EVT_VALID, 1);
        chk({tag, ".idx"},  EVT_IDX, idx);
        chk({tag, ".addr"}, EVT_ADDR, a);
        chk({tag, ".cyc"},  EVT_CYC, cyc);
        chk({tag, ".rw"},   EVT_RW, rw);
        EVT_READY = 1'b1;
        tick(1);
        EVT_READY = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".vld"},  EVT_VALID, 0);
        chk({tag, ".idx"},  EVT_IDX, 0);
        chk({tag, ".addr"}, EVT_ADDR, 0);
        chk({tag, ".cyc"},  EVT_CYC, 0);
        chk({tag, ".rw"},   EVT_RW, 0);
        chk({tag, ".halt"}, HALT, 0);
        chk({tag, ".ovf"},  OVERFLOW, 0);
        chk({tag, ".drop"}, DROP_CNT, 0);
        chk({tag, ".berr"}, BUS_ERR, 0);
    endtask

    int drain_cyc [8] = '{7, 8, 9, 10, 11, 12, 13, 16};

    initial begin
        nRESET = 1'b0; M68K_ADDR = '0; nAS = 1'b1; nLDS = 1'b1; nUDS = 1'b1; M68K_RW = 1'b1;
        CP_WE = 1'b0; CP_IDX = '0; CP_ADDR = '0; CP_EN = 1'b0; CP_STOP = 1'b0;
        EVT_READY = 1'b0; HALT_CLR = 1'b0;
        tick(3);
        chk_idle_outputs("reset");
        nRESET = 1'b1;
        tick(4);

        // Basic read hit with exact latency: EVT_VALID 5 edges after nAS falls.
        cp_write(5'd0, 24'hC11002, 1'b1, 1'b0);
        bus_start(23'h608801, 1'b1, 1'b0, 1'b0);
        tick(4);
        chk("lat.early", EVT_VALID, 0);
        tick(1);
        chk("lat.rise", EVT_VALID, 1);
        tick(4);
        bus_end();
        expect_evt("t1", 5'd0, 24'hC11002, 1, 1'b1);
        chk("t1.empty", EVT_VALID, 0);

        // Lowest index wins; STOP sets HALT; HALT_CLR clears it.
        cp_write(5'd3, 24'hC18F74, 1'b1, 1'b1);
        cp_write(5'd5, 24'hC18F74, 1'b1, 1'b0);
        bus_cycle(23'h60C7BA, 1'b0, 1'b0, 1'b0);
        chk("t2.halt", HALT, 1);
        expect_evt("t2", 5'd3, 24'hC18F74, 2, 1'b0);
        HALT_CLR = 1'b1; tick(1); HALT_CLR = 1'b0;
        chk("t2.clr", HALT, 0);
        // HALT_CLR coincides with the STOP-hit push cycle: set wins.
        bus_start(23'h60C7BA, 1'b0, 1'b0, 1'b0);
        tick(4);
        HALT_CLR = 1'b1; tick(1); HALT_CLR = 1'b0;
        chk("t2.setwins", HALT, 1);
        tick(4);
        bus_end();
        expect_evt("t2b", 5'd3, 24'hC18F74, 3, 1'b0);

        // Odd byte address only for lower-byte-only strobes.
        cp_write(5'd1, 24'hC11B05, 1'b1, 1'b0);
        bus_cycle(23'h608D82, 1'b1, 1'b0, 1'b1);
        expect_evt("t3", 5'd1, 24'hC11B05, 4, 1'b1);
        bus_cycle(23'h608D82, 1'b1, 1'b0, 1'b0);
        chk("t3.word_nohit", EVT_VALID, 0);

        // 10 hits into an 8-deep FIFO with no reader.
        for (int k = 0; k < 10; k++) begin
            bus_cycle(23'h608801, 1'b1, 1'b0, 1'b0);
        end
        chk("t4.drop", DROP_CNT, 2);
        chk("t4.ovf", OVERFLOW, 1);
        // Pop while full on the push cycle: push accepted.
        bus_start(23'h608801, 1'b1, 1'b0, 1'b0);
        tick(4);
        chk("t4.head", EVT_CYC, 6);
        EVT_READY = 1'b1; tick(1); EVT_READY = 1'b0;
        tick(4);
        bus_end();
        chk("t4.drop_hold", DROP_CNT, 2);
        for (int k = 0; k < 8; k++) begin
            expect_evt($sformatf("t4.d%0d", k), 5'd0, 24'hC11002, drain_cyc[k], 1'b1);
        end
        chk("t4.drained", EVT_VALID, 0);
        EVT_READY = 1'b1; tick(2); EVT_READY = 1'b0;
        chk("t4.empty_pop", EVT_VALID, 0);
        chk("t4.ovf_sticky", OVERFLOW, 1);

        // Table write during the compare cycle: old (enabled) value still matches.
        bus_start(23'h608801, 1'b1, 1'b0, 1'b0);
        tick(3);
        cp_write(5'd0, 24'hC11002, 1'b0, 1'b0);
        tick(5);
        bus_end();
        expect_evt("t4.oldval", 5'd0, 24'hC11002, 17, 1'b1);
        bus_cycle(23'h608801, 1'b1, 1'b0, 1'b0);
        chk("t4.disabled", EVT_VALID, 0);

        // Reset between T0 and T0+2 of a hit.
        bus_start(23'h608D82, 1'b1, 1'b0, 1'b1);
        tick(3);
        nRESET = 1'b0; tick(1); nRESET = 1'b1;
        exp_cyc = 0;
        tick(5);
        bus_end();
        chk_idle_outputs("t5");
        bus_cycle(23'h608D82, 1'b1, 1'b0, 1'b1);
        chk("t5.tbl_off", EVT_VALID, 0);
        cp_write(5'd1, 24'hC11B05, 1'b1, 1'b0);
        bus_cycle(23'h608D82, 1'b1, 1'b0, 1'b1);
        expect_evt("t5.after", 5'd1, 24'hC11B05, 2, 1'b1);

        // Long nAS-low cycle.
        bus_start(23'h123456, 1'b1, 1'b0, 1'b0);
        tick(40);
`ifdef NG_BUS_TIMEOUT_EN
        chk("t6.berr", BUS_ERR, 1);
        bus_end();
        expect_evt("t6", 5'h1F, 24'h2468AC, 3, 1'b1);
        chk("t6.one", EVT_VALID, 0);
`else
        chk("t6.berr", BUS_ERR, 0);
        bus_end();
        chk("t6.noevt", EVT_VALID, 0);
`endif
        chk("t6.halt", HALT, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
